// File: rtl/ddr_port_scheduler.sv
// ddr_port_scheduler: round-robin arbiter that shares one DDR controller
// wrapper command interface (acc/we/adr/buf_width/ack/idle) between PORTS
// buffered requesters. It grants one port, forwards that port's latched command,
// counts data-beat acks to the end of the burst, then waits for the wrapper to
// go idle before it arbitrates again.
module ddr_port_scheduler #(
  parameter int PORTS     = 3,
  parameter int PORT_BITS = 2
) (
  input  logic                   local_clk_i,
  input  logic                   local_reset_n_i,
  input  logic [PORTS-1:0]       req_i,
  input  logic [PORTS-1:0]       we_i,
  input  logic [PORTS*32-1:0]    adr_i,
  input  logic [PORTS*4-1:0]     buf_width_i,
  output logic [PORTS-1:0]       gnt_o,
  output logic [PORTS-1:0]       done_o,
  output logic                   acc_o,
  output logic                   we_o,
  output logic [31:0]            adr_o,
  output logic [3:0]             buf_width_o,
  input  logic                   ack_i,
  input  logic                   idle_i,
  output logic                   busy_o,
  output logic [PORT_BITS-1:0]   cur_port_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_next_s;

  logic [PORTS-1:0]     gnt_r;
  logic [PORTS-1:0]     done_r;
  logic                 acc_r;
  logic                 we_r;
  logic [31:0]          adr_r;
  logic [3:0]           bw_r;
  logic [PORT_BITS-1:0] cur_port_r;
  logic [PORT_BITS-1:0] last_grant_r;
  logic [8:0]           cnt_r;

  logic [31:0]          adr_arr_s [PORTS];
  logic [3:0]           bw_arr_s  [PORTS];
  logic [2*PORTS-1:0]   req_dbl_s;
  logic [2*PORTS-1:0]   req_rot_s;
  logic [PORT_BITS:0]   start_s;
  logic                 win_found_s;
  logic [PORT_BITS-1:0] win_idx_s;
  logic [PORTS-1:0]     win_onehot_s;
  logic [3:0]           bw_sel_s;
  logic [3:0]           bw_clamp_s;
  logic [8:0]           last_beat_s;
  logic                 grant_go_s;
  logic                 burst_end_s;
  logic                 drain_end_s;

  // Unpack the flat per-port command buses so the winner can index them directly.
  always_comb begin
    for (int k = 0; k < PORTS; k++) begin
      adr_arr_s[k] = adr_i[k*32 +: 32];
      bw_arr_s[k]  = buf_width_i[k*4 +: 4];
    end
  end

  // Round-robin search: rotate the request vector so that bit 0 is the port after
  // the last grant, then take the first set bit and map it back to a port index.
  always_comb begin
    req_dbl_s   = {req_i, req_i};
    start_s     = {1'b0, last_grant_r} + {{PORT_BITS{1'b0}}, 1'b1};
    req_rot_s   = req_dbl_s >> start_s;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (!win_found_s && req_rot_s[i]) begin
        win_found_s = 1'b1;
        win_idx_s   = PORT_BITS'((int'(start_s) + i) % PORTS);
      end else begin
        win_found_s = win_found_s;
      end
    end
    for (int k = 0; k < PORTS; k++) begin
      win_onehot_s[k] = (win_idx_s == PORT_BITS'(k));
    end
  end

  // Burst sizing: clamp the winner's width to 256 words, and compute the index of
  // the final beat of the granted burst.
  always_comb begin
    bw_sel_s    = bw_arr_s[win_idx_s];
    bw_clamp_s  = (bw_sel_s > 4'd8) ? 4'd8 : bw_sel_s;
    last_beat_s = (9'd1 << bw_r) - 9'd1;
    grant_go_s  = (state_r == ST_IDLE) && win_found_s && idle_i;
    burst_end_s = (state_r == ST_XFER) && ack_i && (cnt_r == last_beat_s);
    drain_end_s = (state_r == ST_DRAIN) && idle_i;
  end

  // FSM state register.
  always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
    if (!local_reset_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = grant_go_s  ? ST_XFER  : ST_IDLE;
      ST_XFER:  state_next_s = burst_end_s ? ST_DRAIN : ST_XFER;
      ST_DRAIN: state_next_s = drain_end_s ? ST_IDLE  : ST_DRAIN;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Registered outputs and burst bookkeeping: latch the command on grant, count
  // acks only while transferring, pulse done and rotate priority on release.
  always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
    if (!local_reset_n_i) begin
      gnt_r        <= '0;
      done_r       <= '0;
      acc_r        <= 1'b0;
      we_r         <= 1'b0;
      adr_r        <= 32'h0000_0000;
      bw_r         <= 4'd0;
      cur_port_r   <= '0;
      last_grant_r <= PORT_BITS'(PORTS - 1);
      cnt_r        <= 9'd0;
    end else begin
      done_r <= '0;
      if (grant_go_s) begin
        gnt_r      <= win_onehot_s;
        cur_port_r <= win_idx_s;
        we_r       <= we_i[win_idx_s];
        adr_r      <= adr_arr_s[win_idx_s];
        bw_r       <= bw_clamp_s;
        acc_r      <= 1'b1;
        cnt_r      <= 9'd0;
      end else if ((state_r == ST_XFER) && ack_i) begin
        cnt_r <= cnt_r + 9'd1;
        if (burst_end_s) begin
          acc_r <= 1'b0;
        end
      end else if (drain_end_s) begin
        done_r       <= gnt_r;
        gnt_r        <= '0;
        last_grant_r <= cur_port_r;
      end
    end
  end

  // Output drive: everything comes straight from registers.
  always_comb begin
    gnt_o       = gnt_r;
    done_o      = done_r;
    acc_o       = acc_r;
    we_o        = we_r;
    adr_o       = adr_r;
    buf_width_o = bw_r;
    cur_port_o  = cur_port_r;
    busy_o      = (state_r != ST_IDLE);
  end

endmodule

// File: doc/ddr_port_scheduler.md
Name: ddr_port_scheduler

Overview:
- Round-robin scheduler that shares the single DDR controller wrapper internal interface (acc/we/adr/buf_width/ack/idle) between PORTS buffered requesters.
- Sits in the DDR clock domain, between per-port buffer logic and ddr_ctrl_wrapper.
- Grants one port at a time, forwards that port's command, counts data-beat acks to the end of the burst, and waits for the controller to go idle before re-arbitrating.

Parameters:
- PORTS, 3, number of requesting ports (1..8).
- PORT_BITS, 2, width of the current-port index; must satisfy 2^PORT_BITS >= PORTS.

Ports:
- local_clk_i  in  1  DDR local clock; only clock in the block.
- local_reset_n_i  in  1  asynchronous, active-low reset.
- req_i  in  PORTS  per-port request; held high until that port's done_o pulse.
- we_i  in  PORTS  per-port write(1)/read(0).
- adr_i  in  PORTS*32  per-port burst start address; port k occupies bits [32k+31:32k].
- buf_width_i  in  PORTS*4  per-port burst size as log2 words.
- gnt_o  out  PORTS  one-hot grant.
- done_o  out  PORTS  one-cycle pulse when the granted port's burst is complete.
- acc_o  out  1  access request to the wrapper.
- we_o  out  1  latched we of the granted port.
- adr_o  out  32  latched address of the granted port.
- buf_width_o  out  4  latched, clamped burst width.
- ack_i  in  1  per-word ack from the wrapper.
- idle_i  in  1  wrapper idle.
- busy_o  out  1  high when state is not IDLE.
- cur_port_o  out  PORT_BITS  index of the granted port; holds its last value after release.

Behaviour:
- Reset values: all outputs 0; last_grant = PORTS-1, so port 0 has first priority.
- Reset is asynchronous. Asserting it mid-burst drops acc_o and gnt_o immediately and produces no done_o.
- State IDLE:
  - Transition requires (|req_i) & idle_i. Winner = first requesting port searching last_grant+1, +2, … modulo PORTS.
  - On transition, register gnt_o, cur_port_o, we_o, adr_o and buf_width_o; set acc_o=1; go to XFER.
  - Grant latency: a request sampled in cycle n (with idle_i=1) gives gnt_o/acc_o high in cycle n+1.
  - With idle_i=0, no grant is issued and the state stays IDLE.
- Burst sizing:
  - buf_width_o = min(buf_width_i, 8).
  - beats = 1 << buf_width_o, range 1..256.
  - The beat counter is 9 bits and is cleared on grant.
- State XFER:
  - acc_o and the latched command are held stable.
  - Each ack_i increments the counter.
  - On ack_i with count == beats-1, acc_o drops in the next cycle and the state moves to DRAIN.
- State DRAIN:
  - Minimum one cycle; waits for idle_i=1.
  - Then: done_o[cur_port] pulses for one cycle, gnt_o clears, last_grant = cur_port, state goes to IDLE.
  - The earliest re-grant is the cycle after the done_o pulse.
- ack_i outside XFER is ignored.
- Changes on req_i, we_i, adr_i or buf_width_i during XFER/DRAIN are ignored. A dropped req still completes and still gives done_o.
- Fairness: a port just served has lowest priority at the next arbitration. Worst-case wait is PORTS-1 bursts.
- PORTS=1: port 0 is always the winner; no rotation is required.

Test Plan:
- Single read: port 1 req, we=0, adr=0x100, bw=2, idle_i=1 -> gnt_o=3'b010 and acc_o=1 one cycle later, adr_o=0x100. After 4 ack_i, acc_o falls. With idle_i=1, done_o=3'b010 pulses once.
- Simultaneous: all three ports request from reset, bw=0 -> grant order 0, 1, 2, then 0. Each burst ends after exactly 1 ack.
- Rotation fairness: port 0 re-requests immediately after its done while port 2 is waiting -> port 2 is granted before port 0.
- Idle gating: req on port 0 with idle_i=0 for 5 cycles -> no grant. idle_i=1 -> grant next cycle. In DRAIN, idle_i held 0 for 3 cycles delays done_o by 3 cycles.
- Clamp/ignore: bw=15 -> buf_width_o=8 and 256 acks end the burst. Stray ack_i in IDLE does not shift the count of the next burst.
- Reset mid-burst: assert local_reset_n_i low after 2 of 8 acks -> acc_o, gnt_o and busy_o are 0 immediately with no done_o. After release, port 0 has priority.
